// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start-bit detection, oversample/bit counting,
// checker and deserializer enables, and frame qualification.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               Start_Glitch,
  input  logic               Par_Err,
  input  logic               Stop_Err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               Start_EN,
  output logic               Par_chk_EN,
  output logic               Stop_chk_EN,
  output logic               deser_en,
  output logic               Data_Valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_t               state_r, state_nxt_s;
  logic [PRESC_W-1:0]   edge_cnt_r, edge_nxt_s;
  logic [3:0]           bit_cnt_r, bit_nxt_s;
  logic                 par_en_r, par_en_nxt_s;
  logic [PRESC_W-1:0]   presc_r, presc_nxt_s;
  logic                 par_err_flag_r, flag_nxt_s;
  logic                 data_valid_r, dv_nxt_s;
  logic [PRESC_W-1:0]   sp_s, be_s;
  logic                 at_sp_s, at_be_s;

  // Check point sits just past mid-bit so registered checker results are settled by bit end.
  assign sp_s    = (presc_r >> 1) + PRESC_W'(2);
  assign be_s    = presc_r - PRESC_W'(1);
  assign at_sp_s = (edge_cnt_r == sp_s);
  assign at_be_s = (edge_cnt_r == be_s);

  // Next-state, counter and flag decode.
  always_comb begin
    state_nxt_s  = state_r;
    edge_nxt_s   = edge_cnt_r;
    bit_nxt_s    = bit_cnt_r;
    par_en_nxt_s = par_en_r;
    presc_nxt_s  = presc_r;
    flag_nxt_s   = par_err_flag_r;
    dv_nxt_s     = 1'b0;

    if (state_r == IDLE) begin
      edge_nxt_s = '0;
      bit_nxt_s  = 4'd0;
    end else if (at_be_s) begin
      edge_nxt_s = '0;
      bit_nxt_s  = bit_cnt_r + 4'd1;
    end else begin
      edge_nxt_s = edge_cnt_r + PRESC_W'(1);
      bit_nxt_s  = bit_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (!RX_IN) begin
          state_nxt_s  = START;
          par_en_nxt_s = PAR_EN;
          presc_nxt_s  = Prescale;
          flag_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (at_be_s && Start_Glitch) begin
          state_nxt_s = IDLE;
          edge_nxt_s  = '0;
          bit_nxt_s   = 4'd0;
        end else if (at_be_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (at_be_s && (bit_cnt_r == LAST_DATA_BIT)) begin
          state_nxt_s = par_en_r ? PARITY : STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (at_be_s) begin
          state_nxt_s = STOP;
          flag_nxt_s  = Par_Err;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (at_be_s) begin
          state_nxt_s = IDLE;
          edge_nxt_s  = '0;
          bit_nxt_s   = 4'd0;
          dv_nxt_s    = !Stop_Err && !par_err_flag_r;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        edge_nxt_s  = '0;
        bit_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counters, latched frame configuration and the Data_Valid register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r        <= IDLE;
      edge_cnt_r     <= '0;
      bit_cnt_r      <= 4'd0;
      par_en_r       <= 1'b0;
      presc_r        <= '0;
      par_err_flag_r <= 1'b0;
      data_valid_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      edge_cnt_r     <= edge_nxt_s;
      bit_cnt_r      <= bit_nxt_s;
      par_en_r       <= par_en_nxt_s;
      presc_r        <= presc_nxt_s;
      par_err_flag_r <= flag_nxt_s;
      data_valid_r   <= dv_nxt_s;
    end
  end

  assign edge_cnt    = edge_cnt_r;
  assign bit_cnt     = bit_cnt_r;
  assign Data_Valid  = data_valid_r;
  assign dat_samp_en = (state_r != IDLE);
  assign Start_EN    = at_sp_s && (state_r == START);
  assign deser_en    = at_sp_s && (state_r == DATA);
  assign Par_chk_EN  = at_sp_s && (state_r == PARITY);
  assign Stop_chk_EN = at_sp_s && (state_r == STOP);

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Receive-side sequencer for the UART RX path. It detects the falling edge of the start bit and runs the per-bit edge counter and bit counter. It issues the sampler, start-check, parity-check, stop-check and deserializer enables, then qualifies the frame with a single-cycle Data_Valid. It sits between RX_IN and the start/parity/stop checkers, data sampler and deserializer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..15).
PRESC_W, 6, width of Prescale and edge_cnt.

Ports:
CLK  input  1  system clock (oversampling clock)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  parity bit present in frame
Prescale  input  PRESC_W  oversampling ratio; legal values 8, 16, 32
Start_Glitch  input  1  registered result from start checker
Par_Err  input  1  registered result from parity checker
Stop_Err  input  1  registered result from stop checker
edge_cnt  output  PRESC_W  oversample position within current bit
bit_cnt  output  4  bit index within frame
dat_samp_en  output  1  data sampler enable
Start_EN  output  1  start checker enable (one-cycle pulse)
Par_chk_EN  output  1  parity checker enable (one-cycle pulse)
Stop_chk_EN  output  1  stop checker enable (one-cycle pulse)
deser_en  output  1  deserializer shift enable (one-cycle pulse)
Data_Valid  output  1  frame accepted (one-cycle pulse)

Behaviour:
- Reset:
  - state=IDLE.
  - edge_cnt=0, bit_cnt=0.
  - Data_Valid=0, internal par_err_flag=0.
  - All enables 0.
  - Reset mid-frame aborts immediately; the next frame needs a fresh RX_IN falling edge.
- States: IDLE, START, DATA, PARITY, STOP.
- Latching: PAR_EN and Prescale are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Derived points:
  - SP = Prescale/2 + 2 is the check point.
  - BE = Prescale-1 is the bit end.
- Counters:
  - In IDLE, both counters are held at 0.
  - In other states, edge_cnt increments every cycle.
  - At edge_cnt==BE, edge_cnt wraps to 0 and bit_cnt increments.
  - The first START cycle has edge_cnt=0, bit_cnt=0.
- dat_samp_en is 1 in every non-IDLE state.
- Checker enables are combinational decodes of registered state and edge_cnt, high only when edge_cnt==SP:
  - Start_EN in START.
  - deser_en in DATA.
  - Par_chk_EN in PARITY.
  - Stop_chk_EN in STOP.
- Checker outputs are valid from SP+1 onward. All FSM decisions are made at edge_cnt==BE.
- Transitions:
  - IDLE: RX_IN==0 -> START; otherwise stay.
  - START @BE: Start_Glitch==1 -> IDLE with counters cleared (glitch rejected); else -> DATA.
  - DATA @BE: if bit_cnt==DATA_WIDTH -> PARITY when latched PAR_EN=1, else STOP; otherwise stay.
  - PARITY @BE: -> STOP unconditionally; par_err_flag <= Par_Err.
  - STOP @BE: -> IDLE; Data_Valid <= !Stop_Err && !par_err_flag.
- par_err_flag is cleared on IDLE->START.
- Data_Valid is registered, high exactly one cycle (the first IDLE cycle after STOP), otherwise 0.
- Back-to-back frames: a start bit seen in that first IDLE cycle enters START on the next edge. There are no dead cycles beyond IDLE's single detection cycle.
- Frame length in non-IDLE cycles is (DATA_WIDTH+2+PAR_EN)*Prescale.
- Illegal Prescale (<8) is unsupported; behaviour is undefined but must not lock up. Any state returns to IDLE within one frame length.

Test Plan:
1. Prescale=8, PAR_EN=0, clean frame 0xA5 LSB-first:
   - deser_en pulses at edge_cnt=6 of bit_cnt 1..8 (8 pulses).
   - Data_Valid=1 for one cycle, 80 cycles after START entry.
2. Prescale=8, RX_IN low for 3 cycles then high (checker returns Start_Glitch=1):
   - FSM returns to IDLE at edge_cnt=7 of bit 0.
   - No deser_en, no Data_Valid.
3. Prescale=16, PAR_EN=1, Par_Err=1 at parity:
   - Par_chk_EN pulses once at edge_cnt=10, bit_cnt=9.
   - STOP still executes; Data_Valid stays 0.
   - A following good frame yields Data_Valid=1 (flag cleared).
4. Prescale=8, PAR_EN=0, Stop_Err=1:
   - Stop_chk_EN pulses at bit_cnt=9, edge_cnt=6.
   - Data_Valid stays 0; state is IDLE after 80 cycles.
5. Two frames back-to-back, Prescale=8: second start bit begins the cycle Data_Valid is high; both frames give Data_Valid.
6. RST driven low during DATA at bit_cnt=4:
   - All outputs are 0 asynchronously.
   - After release with RX_IN high, FSM stays IDLE.
   - A subsequent full frame decodes normally.
